// File: rtl/gpout_pad_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gpout_pad_arbiter: round-robin owner select for one shared output pad.  |
// | Optional hold-time preemption via GPOUT_ARB_PREEMPT_EN.  Rev 1.0        |
// +------------------------------------------------------------------------+
module gpout_pad_arbiter #(
  parameter int   NUM_REQ  = 4,
  parameter int   HOLD_MAX = 16,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               pad_out
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e               state_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        last_owner_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 pad_q;

  logic [IW-1:0]        pick_d;
  logic [NUM_REQ-1:0]   pick_oh_d;
  logic [NUM_REQ-1:0]   owner_oh_d;
  logic                 release_d;
  logic                 preempt_d;

  // Walk from farthest to nearest so the nearest high bit after last_owner wins.
  always_comb begin
    pick_d = last_owner_q;
    for (int i = NUM_REQ; i >= 1; i--) begin
      int idx;
      idx = (int'(last_owner_q) + i) % NUM_REQ;
      if (req[IW'(idx)]) begin
        pick_d = IW'(idx);
      end
    end
    pick_oh_d          = '0;
    pick_oh_d[pick_d]  = 1'b1;
    owner_oh_d         = '0;
    owner_oh_d[owner_q] = 1'b1;
    release_d          = ~req[owner_q];
  end

`ifdef GPOUT_ARB_PREEMPT_EN
  localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_q;

  assign preempt_d = (hold_q == C_HOLD_LAST) && (|(req & ~owner_oh_d));
`else
  // Without preemption HOLD_MAX has no effect on behaviour.
  assign preempt_d = 1'b0 & (HOLD_MAX < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_REQ - 1);
      gnt_q        <= '0;
      pad_q        <= IDLE_VAL;
`ifdef GPOUT_ARB_PREEMPT_EN
      hold_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_GAP: begin
          if (|req) begin
            state_q      <= S_GRANT;
            owner_q      <= pick_d;
            last_owner_q <= pick_d;
            gnt_q        <= pick_oh_d;
            pad_q        <= req_data[pick_d];
`ifdef GPOUT_ARB_PREEMPT_EN
            hold_q       <= '0;
`endif
          end else begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            pad_q   <= IDLE_VAL;
          end
        end
        S_GRANT: begin
          if (release_d || preempt_d) begin
            state_q <= S_GAP;
            gnt_q   <= '0;
            pad_q   <= IDLE_VAL;
          end else begin
            state_q <= S_GRANT;
            pad_q   <= req_data[owner_q];
`ifdef GPOUT_ARB_PREEMPT_EN
            if (hold_q != C_HOLD_LAST) begin
              hold_q <= hold_q + 8'd1;
            end
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          pad_q   <= IDLE_VAL;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q == S_GRANT);
  assign pad_out = pad_q;

endmodule
`default_nettype wire

// File: tb/tb_gpout_pad_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_gpout_pad_arbiter: directed scoreboard bench for gpout_pad_arbiter.  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_gpout_pad_arbiter;

  typedef struct {
    logic [3:0] g;
    logic       p;
    string      tag;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] req_data;
  logic [3:0] gnt;
  logic       busy;
  logic       pad_out;

  int   checks;
  int   errors;
  exp_t exp_q[$];

  gpout_pad_arbiter #(
    .NUM_REQ (4),
    .HOLD_MAX(4),
    .IDLE_VAL(1'b0)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_data(req_data),
    .gnt     (gnt),
    .busy    (busy),
    .pad_out (pad_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    e = exp_q.pop_front();
    checks++;
    assert (gnt === e.g) else begin
      errors++;
      $error("FAIL %s gnt: observed %b expected %b", e.tag, gnt, e.g);
    end
    checks++;
    assert (pad_out === e.p) else begin
      errors++;
      $error("FAIL %s pad_out: observed %b expected %b", e.tag, pad_out, e.p);
    end
    checks++;
    assert (busy === (|e.g)) else begin
      errors++;
      $error("FAIL %s busy: observed %b expected %b", e.tag, busy, |e.g);
    end
  endtask

  // Apply inputs for one edge, queue what must appear after that edge, then check it.
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] d,
                       input logic [3:0] eg, input logic ep, input string tag);
    exp_t e;
    reset    = r;
    req      = rq;
    req_data = d;
    e.g = eg;
    e.p = ep;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    req      = '0;
    req_data = '0;

    // Requests during reset are ignored.
    drive(1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, "reset");

    drive(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, "first_grant");
    drive(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, "pad_follows");
    drive(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, "pad_follows2");
    drive(1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, "release_gap");
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle");

    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "reset2");
    drive(1'b0, 4'b1010, 4'b1010, 4'b0010, 1'b1, "rr_first");
    drive(1'b0, 4'b1010, 4'b1010, 4'b0010, 1'b1, "rr_hold");
    drive(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, "rr_gap");
    drive(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, "rr_next");
    drive(1'b0, 4'b0011, 4'b0001, 4'b0000, 1'b0, "wrap_gap");
    drive(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b1, "wrap_grant");
    drive(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, "nonowner_drop");
    drive(1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, "drop_gap");
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "no_latch");

    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "reset3");
`ifdef GPOUT_ARB_PREEMPT_EN
    for (int k = 0; k < 23; k++) begin
      logic [3:0] eg;
      case (k % 10)
        0, 1, 2, 3: eg = 4'b0001;
        5, 6, 7, 8: eg = 4'b0010;
        default:    eg = 4'b0000;
      endcase
      drive(1'b0, 4'b0011, 4'b0011, eg, |eg, "preempt_rot");
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 4'b0001, 4'b0011, 4'b0001, 1'b1, "preempt_sat");
    end
`else
    for (int k = 0; k < 100; k++) begin
      logic [3:0] d;
      d = 4'($urandom);
      drive(1'b0, 4'b0011, d, 4'b0001, d[0], "no_preempt");
    end
`endif

    drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "pre_rst_gap");
    drive(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, "pre_rst_grant");
    // Reset mid-grant: no GAP, and priority restarts at requester 0.
    drive(1'b1, 4'b1010, 4'b1111, 4'b0000, 1'b0, "mid_reset");
    drive(1'b0, 4'b1010, 4'b0010, 4'b0010, 1'b1, "post_reset_pick");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
